// File: rtl/sisc_exec_ctrl.sv
// SISC execution core, part 1: multi-cycle control FSM, 32-bit ALU with
// {C,N,V,Z} generation and the ALU/memory write-back select.
module sisc_exec_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic [DW-1:0] ir,
    input  logic [DW-1:0] rsa,
    input  logic [DW-1:0] rsb,
    input  logic [3:0]    stat,
    input  logic [DW-1:0] mem_data,
    output logic          rf_we,
    output logic          wb_sel,
    output logic [DW-1:0] wb_data,
    output logic [DW-1:0] alu_result,
    output logic [3:0]    cc,
    output logic          stat_en,
    output logic          halted
);

    typedef enum logic [2:0] {
        START0    = 3'd0,
        START1    = 3'd1,
        FETCH     = 3'd2,
        DECODE    = 3'd3,
        EXECUTE   = 3'd4,
        MEM       = 3'd5,
        WRITEBACK = 3'd6,
        HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ALUR = 4'b0001;
    localparam logic [3:0] OP_ALUI = 4'b0010;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_AND = 4'h2;
    localparam logic [3:0] FN_OR  = 4'h3;
    localparam logic [3:0] FN_XOR = 4'h4;
    localparam logic [3:0] FN_NOT = 4'h5;
    localparam logic [3:0] FN_SHL = 4'h6;
    localparam logic [3:0] FN_SHR = 4'h7;
    localparam logic [3:0] FN_MOV = 4'h8;

    state_t r_state, w_state_nxt;

    logic [3:0]    w_opcode;
    logic [3:0]    w_mm;
    logic          w_is_alu_op;
    logic          w_mm_defined;
    logic          w_commit;
    logic [DW-1:0] w_b;
    logic [DW:0]   w_sum_add;
    logic [DW:0]   w_sum_sub;
    logic [DW-1:0] w_res;
    logic          w_c;
    logic          w_v;
    logic [DW-1:0] r_alu_result;
    logic          w_unused;

    assign w_opcode     = ir[31:28];
    assign w_mm         = ir[27:24];
    assign w_is_alu_op  = (w_opcode == OP_ALUR) || (w_opcode == OP_ALUI);
    assign w_mm_defined = (w_mm <= FN_MOV);
    // Only a real ALU instruction with a defined function may touch state.
    assign w_commit     = w_is_alu_op && w_mm_defined;

    assign w_b = (w_opcode == OP_ALUI) ? {{(DW-16){ir[15]}}, ir[15:0]} : rsb;

    // Subtract is A + ~B + 1 so that carry-out means "no borrow".
    assign w_sum_add = {1'b0, rsa} + {1'b0, w_b};
    assign w_sum_sub = {1'b0, rsa} + {1'b0, ~w_b} + {{DW{1'b0}}, 1'b1};

    always_comb begin
        w_res = rsa;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_mm)
            FN_ADD: begin
                w_res = w_sum_add[DW-1:0];
                w_c   = w_sum_add[DW];
                w_v   = (rsa[DW-1] == w_b[DW-1]) && (w_res[DW-1] != rsa[DW-1]);
            end
            FN_SUB: begin
                w_res = w_sum_sub[DW-1:0];
                w_c   = w_sum_sub[DW];
                w_v   = (rsa[DW-1] != w_b[DW-1]) && (w_res[DW-1] != rsa[DW-1]);
            end
            FN_AND: w_res = rsa & w_b;
            FN_OR:  w_res = rsa | w_b;
            FN_XOR: w_res = rsa ^ w_b;
            FN_NOT: w_res = ~rsa;
            FN_SHL: w_res = rsa << w_b[4:0];
            FN_SHR: w_res = rsa >> w_b[4:0];
            FN_MOV: w_res = w_b;
            default: w_res = rsa;
        endcase
    end

    assign cc = {w_c, w_res[DW-1], w_v, (w_res == '0)};

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= START0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rf_we       = 1'b0;
        stat_en     = 1'b0;
        halted      = 1'b0;
        case (r_state)
            START0:    w_state_nxt = START1;
            START1:    w_state_nxt = FETCH;
            FETCH:     w_state_nxt = DECODE;
            DECODE:    w_state_nxt = (w_opcode == OP_HLT) ? HALT : EXECUTE;
            EXECUTE: begin
                w_state_nxt = MEM;
                stat_en     = w_commit;
            end
            MEM:       w_state_nxt = WRITEBACK;
            WRITEBACK: begin
                w_state_nxt = FETCH;
                rf_we       = w_commit;
            end
            HALT: begin
                w_state_nxt = HALT;
                halted      = 1'b1;
            end
            default:   w_state_nxt = START0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_alu_result <= '0;
        end else if (r_state == EXECUTE) begin
            r_alu_result <= w_res;
        end
    end

    assign alu_result = r_alu_result;

    // Memory loads are not part of this instruction subset, so the ALU path
    // is always selected; the mux is kept for the load path to come.
    assign wb_sel  = 1'b1;
    assign wb_data = wb_sel ? r_alu_result : mem_data;

    // Branch status and register addresses are consumed elsewhere.
    assign w_unused = ^{stat, ir[23:16], (w_opcode == OP_NOP)};

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Directed bench for sisc_exec_ctrl: startup timing, ALU functions and flags,
// no-write opcodes, HLT and asynchronous reset mid-instruction.
module tb_sisc_exec_ctrl;

    logic        clk;
    logic        rst_f;
    logic [31:0] ir;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [3:0]  stat;
    logic [31:0] mem_data;
    logic        rf_we;
    logic        wb_sel;
    logic [31:0] wb_data;
    logic [31:0] alu_result;
    logic [3:0]  cc;
    logic        stat_en;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    sisc_exec_ctrl #(.DW(32)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .ir         (ir),
        .rsa        (rsa),
        .rsb        (rsb),
        .stat       (stat),
        .mem_data   (mem_data),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .wb_data    (wb_data),
        .alu_result (alu_result),
        .cc         (cc),
        .stat_en    (stat_en),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one instruction starting in FETCH; returns to FETCH afterwards.
    task automatic run_instr(input string tag, input logic [31:0] i_ir,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic [3:0] exp_cc,
                             input int exp_writes);
        int n_we, n_st;
        logic [3:0]  cc_ex;
        logic        st_ex, we_wb;
        logic [31:0] res_mem, wbd;
        ir = i_ir; rsa = a; rsb = b;
        n_we = 0; n_st = 0;
        cc_ex = '0; st_ex = 1'b0; we_wb = 1'b0; res_mem = '0; wbd = '0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_we += int'(rf_we);
            n_st += int'(stat_en);
            if (k == 2) begin cc_ex = cc; st_ex = stat_en; end
            if (k == 3) res_mem = alu_result;
            if (k == 4) begin we_wb = rf_we; wbd = wb_data; end
        end
        check({tag, " cc"},       {28'd0, cc_ex}, {28'd0, exp_cc});
        check({tag, " result"},   res_mem, exp_res);
        check({tag, " rf_we cnt"}, n_we, exp_writes);
        check({tag, " stat cnt"},  n_st, exp_writes);
        if (exp_writes != 0) begin
            check({tag, " stat_en@EX"}, {31'd0, st_ex}, 32'd1);
            check({tag, " rf_we@WB"},   {31'd0, we_wb}, 32'd1);
            check({tag, " wb_data"},    wbd, exp_res);
        end
    endtask

    // Opcodes with no architectural effect: only the write counts matter.
    task automatic run_nowrite(input string tag, input logic [31:0] i_ir);
        int n_we, n_st;
        ir = i_ir; rsa = 32'h1234_5678; rsb = 32'h9ABC_DEF0;
        n_we = 0; n_st = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_we += int'(rf_we);
            n_st += int'(stat_en);
        end
        check({tag, " rf_we cnt"}, n_we, 0);
        check({tag, " stat cnt"},  n_st, 0);
    endtask

    initial begin
        int n_we;
        rst_f = 1'b0; ir = 32'h1031_2000; rsa = 32'd1; rsb = 32'd2;
        stat = 4'h0; mem_data = 32'hDEAD_BEEF;
        tick(); tick();
        check("rst rf_we",   {31'd0, rf_we},   32'd0);
        check("rst stat_en", {31'd0, stat_en}, 32'd0);
        check("rst halted",  {31'd0, halted},  32'd0);
        check("rst alu",     alu_result,       32'd0);
        check("rst wb_sel",  {31'd0, wb_sel},  32'd1);
        check("rst wb_data", wb_data,          32'd0);

        // Startup: release at a falling edge, then count edges.
        rst_f = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("start e%0d stat_en", e), {31'd0, stat_en}, (e == 4) ? 32'd1 : 32'd0);
            check($sformatf("start e%0d rf_we", e),   {31'd0, rf_we},   (e == 6) ? 32'd1 : 32'd0);
            if (e == 4) check("start cc", {28'd0, cc}, 32'd0);
            if (e == 6) check("start wb_data", wb_data, 32'd3);
        end

        run_instr("add ovf",   32'h1031_2000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b0110, 1);
        run_instr("sub eq",    32'h1131_2000, 32'd5,         32'd5,         32'h0000_0000, 4'b1001, 1);
        run_instr("sub borrow",32'h1131_2000, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b0100, 1);
        run_instr("addi",      32'h2031_FFFF, 32'h10,        32'hAAAA_AAAA, 32'h0000_000F, 4'b1000, 1);
        run_instr("and",       32'h1231_2000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000, 1);
        run_instr("or zero",   32'h1331_2000, 32'd0,         32'd0,         32'h0000_0000, 4'b0001, 1);
        run_instr("xor",       32'h1431_2000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 4'b0000, 1);
        run_instr("not",       32'h1531_2000, 32'd0,         32'd7,         32'hFFFF_FFFF, 4'b0100, 1);
        run_instr("shl31",     32'h1631_2000, 32'd1,         32'd31,        32'h8000_0000, 4'b0100, 1);
        run_instr("shl0",      32'h1631_2000, 32'h1234,      32'd0,         32'h0000_1234, 4'b0000, 1);
        run_instr("shr",       32'h1731_2000, 32'h8000_0000, 32'h21,        32'h4000_0000, 4'b0000, 1);
        run_instr("mov",       32'h1831_2000, 32'h55,        32'd0,         32'h0000_0000, 4'b0001, 1);
        run_instr("undef mm",  32'h1A31_2000, 32'h55,        32'h77,        32'h0000_0055, 4'b0000, 0);
        run_nowrite("nop", 32'h0000_0000);
        run_nowrite("op3", 32'h3031_2000);

        // Reset during MEM: the pending write must never appear.
        ir = 32'h1031_2000; rsa = 32'd4; rsb = 32'd4;
        tick(); tick(); tick();
        check("mid mem alu", alu_result, 32'd8);
        rst_f = 1'b0;
        #1;
        check("mid rst rf_we", {31'd0, rf_we}, 32'd0);
        check("mid rst alu",   alu_result,     32'd0);
        tick();
        check("mid held rf_we", {31'd0, rf_we}, 32'd0);
        rst_f = 1'b1;
        n_we = 0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_we += int'(rf_we);
        end
        check("mid restart no we", n_we, 0);
        tick();
        check("mid restart we e6", {31'd0, rf_we}, 32'd1);
        check("mid restart wb",    wb_data,        32'd8);
        tick();

        // HLT: halts until reset, no writes even with an ALU op presented.
        ir = 32'hF000_0000;
        tick(); tick();
        check("hlt halted", {31'd0, halted}, 32'd1);
        ir = 32'h1031_2000; rsa = 32'd1; rsb = 32'd1;
        n_we = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_we += int'(rf_we) + int'(stat_en);
        end
        check("hlt no writes", n_we, 0);
        check("hlt still",     {31'd0, halted}, 32'd1);
        rst_f = 1'b0;
        #1;
        check("hlt rst clears", {31'd0, halted}, 32'd0);
        tick();
        rst_f = 1'b1;
        tick();
        check("hlt post rst", {31'd0, halted}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
